// File: rtl/uart_autobaud.sv
// Auto-baud detector: times the host 0x55 sync character on rx and
// derives the UART core clock divider from five falling-edge timestamps.
module uart_autobaud #(
  parameter int PRESCALER_COUNT = 8,
  parameter int COUNT_WIDTH     = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        start,
  output logic        set_clock_div,
  output logic [31:0] user_clock_div,
  output logic        locked,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, WAIT_HIGH, WAIT_START, MEASURE, COMPUTE, DONE, FAIL
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] MAX = '1;
  localparam logic [63:0] HALF = 64'(4 * PRESCALER_COUNT);
  localparam logic [63:0] FULL = 64'(8 * PRESCALER_COUNT);

  state_t state, state_n;

  logic sync1, sync2, prev;
  logic fall;

  logic [COUNT_WIDTH-1:0] total;
  logic [COUNT_WIDTH-1:0] interval;
  logic [COUNT_WIDTH-1:0] i0;
  logic [COUNT_WIDTH-1:0] diff;
  logic [2:0]             edges;
  logic                   bad;
  logic [63:0]            quo;

  assign fall = prev & ~sync2;
  assign diff = (interval >= i0) ? interval - i0 : i0 - interval;
  assign bad  = diff > (i0 >> 2);
  assign quo  = (64'(total) + HALF) / FULL;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, FAIL: begin
        if (start) state_n = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (sync2) state_n = WAIT_START;
      end
      WAIT_START: begin
        if (total == MAX) state_n = FAIL;
        else if (fall)    state_n = MEASURE;
      end
      MEASURE: begin
        // edges counts the edge before this one; >=2 means I0 exists
        if (total == MAX)                    state_n = FAIL;
        else if (fall && edges >= 3'd2 && bad) state_n = FAIL;
        else if (fall && edges == 3'd4)      state_n = COMPUTE;
      end
      COMPUTE: begin
        state_n = (quo == 64'd0) ? FAIL : DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      sync1          <= 1'b1;
      sync2          <= 1'b1;
      prev           <= 1'b1;
      total          <= '0;
      interval       <= '0;
      i0             <= '0;
      edges          <= '0;
      set_clock_div  <= 1'b0;
      user_clock_div <= '0;
      locked         <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state <= state_n;
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            total    <= '0;
            interval <= '0;
            i0       <= '0;
            edges    <= '0;
          end
        end
        WAIT_START: begin
          if (fall) begin
            total    <= '0;
            interval <= '0;
            edges    <= 3'd1;
          end else if (total != MAX) begin
            total <= total + 1'b1;
          end
        end
        MEASURE: begin
          if (total != MAX) total <= total + 1'b1;
          if (fall) begin
            edges    <= edges + 3'd1;
            interval <= 1;
            if (edges == 3'd1) i0 <= interval;
          end else begin
            interval <= interval + 1'b1;
          end
        end
        default: ;
      endcase
      set_clock_div <= (state == COMPUTE) && (state_n == DONE);
      if ((state == COMPUTE) && (state_n == DONE))
        user_clock_div <= quo[31:0];
      locked <= state_n == DONE;
      error  <= state_n == FAIL;
      busy   <= (state_n == WAIT_HIGH) || (state_n == WAIT_START) ||
                (state_n == MEASURE)   || (state_n == COMPUTE);
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboarded bench for uart_autobaud: frame-level reference model,
// queue of expected dividers, monitor popping on every set_clock_div.
module tb_uart_autobaud;

  localparam int P = 8;

  typedef int len_t[10];

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic        rx0 = 1'b1, rx1 = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        set0, set1;
  logic [31:0] div0, div1;
  logic        locked0, locked1, busy0, busy1, error0, error1;

  int errors = 0;
  int checks = 0;
  int pulses1 = 0;
  int expq[$];
  int last_div = 0;

  always #5 clk = ~clk;

  uart_autobaud #(.PRESCALER_COUNT(P), .COUNT_WIDTH(24)) dut0 (
    .clk(clk), .rst(rst0), .rx(rx0), .start(start0),
    .set_clock_div(set0), .user_clock_div(div0),
    .locked(locked0), .busy(busy0), .error(error0)
  );

  uart_autobaud #(.PRESCALER_COUNT(P), .COUNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst1), .rx(rx1), .start(start1),
    .set_clock_div(set1), .user_clock_div(div1),
    .locked(locked1), .busy(busy1), .error(error1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic pulse_start(input int sel);
    tick();
    if (sel == 0) start0 = 1'b1;
    else start1 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  function automatic len_t make_len(input int b, input int jit);
    len_t l;
    for (int i = 0; i < 10; i++)
      l[i] = b + ((jit > 0) ? int'($urandom_range(0, jit)) : 0);
    return l;
  endfunction

  function automatic logic lvl_of(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Reference: timestamps of falling edges in the frame, spacing rule,
  // rounded divider from the edge-1..edge-5 span.
  function automatic void model(input logic [7:0] b, input len_t len,
                                output int div, output bit ok);
    int e[$];
    int t = 0;
    int total, ref0, iv;
    logic prv = 1'b1;
    logic lv;
    for (int i = 0; i < 10; i++) begin
      lv = lvl_of(b, i);
      if (prv && !lv) e.push_back(t);
      t += len[i];
      prv = lv;
    end
    ok = 1'b0;
    div = 0;
    if (e.size() >= 5) begin
      total = e[4] - e[0];
      ref0 = e[1] - e[0];
      ok = 1'b1;
      for (int k = 2; k < 5; k++) begin
        iv = e[k] - e[k-1];
        if (((iv > ref0) ? iv - ref0 : ref0 - iv) > ref0 / 4) ok = 1'b0;
      end
      div = (total + 4 * P) / (8 * P);
      if (div == 0) ok = 1'b0;
    end
  endfunction

  task automatic send_frame(input int sel, input logic [7:0] b,
                            input len_t len, input int g_bit,
                            input int g_off);
    logic lv;
    for (int i = 0; i < 10; i++) begin
      lv = lvl_of(b, i);
      drive(sel, lv);
      if (i == g_bit) begin
        repeat (g_off) tick();
        drive(sel, 1'b0);
        repeat (3) tick();
        drive(sel, lv);
        repeat (len[i] - g_off - 3) tick();
      end else begin
        repeat (len[i]) tick();
      end
    end
    drive(sel, 1'b1);
  endtask

  task automatic wait_idle0(input string name);
    int n = 0;
    while (busy0 && n < 4000) begin
      tick();
      n++;
    end
    if (busy0) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: busy still %0d, required 0", name, busy0);
    end
  endtask

  task automatic run_clean(input string name, input len_t len);
    int d;
    bit ok;
    model(8'h55, len, d, ok);
    if (ok) expq.push_back(d);
    pulse_start(0);
    repeat (20) tick();
    send_frame(0, 8'h55, len, -1, 0);
    wait_idle0(name);
    repeat (4) tick();
    chk({name, "_locked"}, {31'd0, locked0}, {31'd0, ok});
    chk({name, "_error"}, {31'd0, error0}, {31'd0, !ok});
    if (ok) last_div = d;
    chk({name, "_div"}, div0, last_div);
  endtask

  always @(negedge clk) begin
    if (!rst0 && set0) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: div=%0d, required no pulse", div0);
      end else begin
        chk("pulse_div", div0, expq.pop_front());
        chk("pulse_locked", {31'd0, locked0}, 32'd1);
        chk("pulse_busy", {31'd0, busy0}, 32'd0);
        chk("pulse_error", {31'd0, error0}, 32'd0);
      end
    end
    if (!rst1 && set1) pulses1++;
  end

  task automatic main_seq();
    len_t l;
    repeat (3) tick();
    chk("rst_set", {31'd0, set0}, 32'd0);
    chk("rst_div", div0, 32'd0);
    chk("rst_locked", {31'd0, locked0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_error", {31'd0, error0}, 32'd0);
    rst0 = 1'b0;
    repeat (3) tick();

    run_clean("clean640", make_len(640, 0));
    run_clean("round644", make_len(644, 0));
    for (int i = 0; i < 6; i++)
      run_clean("random", make_len(int'($urandom_range(32, 150)), 3));

    // start during MEASURE must be ignored
    l = make_len(100, 0);
    expq.push_back(13);
    pulse_start(0);
    repeat (10) tick();
    fork
      send_frame(0, 8'h55, l, -1, 0);
      begin
        repeat (300) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
      end
    join
    wait_idle0("midstart");
    repeat (4) tick();
    last_div = 13;
    chk("midstart_div", div0, 32'd13);
    chk("midstart_locked", {31'd0, locked0}, 32'd1);

    // line low at arm time
    rx0 = 1'b0;
    pulse_start(0);
    repeat (200) tick();
    chk("lowarm_busy", {31'd0, busy0}, 32'd1);
    chk("lowarm_locked", {31'd0, locked0}, 32'd0);
    rx0 = 1'b1;
    repeat (50) tick();
    expq.push_back(11);
    send_frame(0, 8'h55, make_len(90, 0), -1, 0);
    wait_idle0("lowarm");
    repeat (4) tick();
    last_div = 11;
    chk("lowarm_div", div0, 32'd11);

    // glitch inside d2
    pulse_start(0);
    repeat (20) tick();
    send_frame(0, 8'h55, make_len(640, 0), 3, 100);
    wait_idle0("glitch");
    chk("glitch_error", {31'd0, error0}, 32'd1);
    chk("glitch_locked", {31'd0, locked0}, 32'd0);
    chk("glitch_div", div0, last_div);

    // reset after edge 3
    pulse_start(0);
    repeat (20) tick();
    fork
      send_frame(0, 8'h55, make_len(200, 0), -1, 0);
      begin
        repeat (820) tick();
        rst0 = 1'b1;
        repeat (3) tick();
        chk("abort_set", {31'd0, set0}, 32'd0);
        chk("abort_div", div0, 32'd0);
        chk("abort_locked", {31'd0, locked0}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_error", {31'd0, error0}, 32'd0);
        rst0 = 1'b0;
      end
    join
    repeat (20) tick();
    chk("abort_idle", {31'd0, busy0}, 32'd0);
    last_div = 0;
    run_clean("relock", make_len(120, 0));
    chk("relock_val", div0, 32'd15);
    chk("pending", expq.size(), 0);
  endtask

  task automatic aux_seq();
    int n;
    repeat (3) tick();
    rst1 = 1'b0;
    repeat (3) tick();
    pulse_start(1);
    repeat (10) tick();
    send_frame(1, 8'h55, make_len(50, 0), -1, 0);
    repeat (10) tick();
    chk("to_pre_div", div1, 32'd6);
    chk("to_pre_locked", {31'd0, locked1}, 32'd1);
    pulse_start(1);
    repeat (10) tick();
    rx1 = 1'b0;
    n = 0;
    while (!error1 && n < 70000) begin
      tick();
      n++;
      if (n == 450) rx1 = 1'b1;
    end
    checks++;
    if (n < 65535 || n > 65545) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d, required 65535..65545", n);
    end
    chk("to_error", {31'd0, error1}, 32'd1);
    chk("to_locked", {31'd0, locked1}, 32'd0);
    chk("to_busy", {31'd0, busy1}, 32'd0);
    chk("to_div", div1, 32'd6);
    chk("to_pulses", pulses1, 32'd1);
  endtask

  initial begin
    fork
      main_seq();
      aux_seq();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
